// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - FSM encoding and elaboration helpers for the FFT address sequencer
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fft_state_t;

  localparam int LOG2N_MIN    = 2;
  localparam int LOG2N_MAX    = 12;
  localparam int BFLY_LAT_MIN = 1;
  localparam int BFLY_LAT_MAX = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit params_legal(input int log2n, input int bfly_lat);
    return (log2n >= LOG2N_MIN) && (log2n <= LOG2N_MAX) &&
           (bfly_lat >= BFLY_LAT_MIN) && (bfly_lat <= BFLY_LAT_MAX);
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// rtl/fft_delay_line.sv - fixed-depth shift register with enable and synchronous clear
module fft_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else if (en) begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/fft_addr_gen.sv
// rtl/fft_addr_gen.sv - in-place radix-2 DIT FFT address/twiddle sequencer
// Issues one butterfly per unheld READ cycle and replays its addresses BFLY_LAT cycles later for write-back.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N    = 5,
  parameter int BFLY_LAT = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fft_start,
  input  logic                      fft_inverse,
  input  logic                      hold,
  output logic                      fft_busy,
  output logic                      fft_done,
  output logic                      rd_en,
  output logic [LOG2N-1:0]          address_a,
  output logic [LOG2N-1:0]          address_b,
  output logic [LOG2N-2:0]          twiddle_address,
  output logic                      twiddle_conj,
  output logic [clog2(LOG2N)-1:0]   stage,
  output logic                      mem_wr,
  output logic [LOG2N-1:0]          wr_address_a,
  output logic [LOG2N-1:0]          wr_address_b
);

  localparam int SW = clog2(LOG2N);
  localparam int JW = LOG2N - 1;
  localparam int DW = clog2(BFLY_LAT + 1);

  if (!params_legal(LOG2N, BFLY_LAT)) begin : g_param_check
    $error("fft_addr_gen: LOG2N must be 2..12 and BFLY_LAT 1..8");
  end

  fft_state_t       state_q, state_d;
  logic [SW-1:0]    s_q;
  logic [JW-1:0]    j_q;
  logic [DW-1:0]    drain_q;
  logic             conj_q;
  logic [LOG2N-1:0] held_a, held_b;
  logic [LOG2N-2:0] held_tw;
  logic [LOG2N-1:0] a_c, b_c, j_ext, span, pos, tw_full;
  logic [LOG2N-2:0] tw_c;
  logic             j_last, s_last, drain_last, wr_pipe;
  int               s_int;

  assign j_last     = &j_q;
  assign s_last     = (s_q == SW'(LOG2N - 1));
  assign drain_last = (drain_q == DW'(BFLY_LAT - 1));
  assign s_int      = int'(s_q);

  // Butterfly j of stage s: insert a zero at bit s of j to get the upper leg.
  always_comb begin
    j_ext   = {1'b0, j_q};
    span    = LOG2N'(1) << s_int;
    pos     = j_ext & (span - LOG2N'(1));
    a_c     = ((j_ext >> s_int) << (s_int + 1)) | pos;
    b_c     = a_c + span;
    tw_full = pos << (LOG2N - 1 - s_int);
    tw_c    = tw_full[LOG2N-2:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (fft_start) state_d = ST_READ;
      ST_READ:  if (j_last) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_last) state_d = s_last ? ST_DONE : ST_READ;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      j_q     <= '0;
      drain_q <= '0;
      conj_q  <= 1'b0;
      held_a  <= '0;
      held_b  <= '0;
      held_tw <= '0;
    end else if (!hold) begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (fft_start) begin
          s_q    <= '0;
          j_q    <= '0;
          conj_q <= fft_inverse;
        end
        ST_READ: begin
          held_a  <= a_c;
          held_b  <= b_c;
          held_tw <= tw_c;
          drain_q <= '0;
          if (!j_last) j_q <= j_q + JW'(1);
        end
        ST_DRAIN: begin
          if (!drain_last) begin
            drain_q <= drain_q + DW'(1);
          end else if (!s_last) begin
            s_q <= s_q + SW'(1);
            j_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_en           = (state_q == ST_READ) && !hold;
  assign fft_busy        = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign fft_done        = (state_q == ST_DONE) && !hold;
  assign address_a       = rd_en ? a_c : held_a;
  assign address_b       = rd_en ? b_c : held_b;
  assign twiddle_address = rd_en ? tw_c : held_tw;
  assign twiddle_conj    = conj_q;
  assign stage           = s_q;

  // Frozen while held so the butterfly pipeline and write-back stay aligned.
  fft_delay_line #(
    .WIDTH (1 + 2 * LOG2N),
    .DEPTH (BFLY_LAT)
  ) u_wb_pipe (
    .clk   (clk),
    .clear (rst),
    .en    (!hold),
    .din   ({rd_en, a_c, b_c}),
    .dout  ({wr_pipe, wr_address_a, wr_address_b})
  );

  assign mem_wr = wr_pipe && !hold;

endmodule
